// File: rtl/rotate_unit.sv
// rotate_unit: iterative rotate engine for the flare32 ALU path.
// Rotates left/right, plain or through carry, by at most STEP bits per cycle
// under a start/busy/done handshake. Results only appear on entry to DONE.
module rotate_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int AMT_WIDTH  = 5,
   parameter int STEP       = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  start,
   input  logic                  op_right,
   input  logic                  op_thru_carry,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [AMT_WIDTH-1:0]  amount,
   input  logic                  carry_in,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  carry_out,
   output logic                  zero_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [DATA_WIDTH:0]   r_work;
   logic [AMT_WIDTH-1:0]  r_remaining;
   logic                  r_right;
   logic                  r_thru;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_carryOut;
   logic                  r_zero;

   logic [AMT_WIDTH-1:0]  w_step;
   logic [AMT_WIDTH-1:0]  w_remNext;
   logic [DATA_WIDTH:0]   w_workNext;
   logic                  w_finalCarry;

   // Rotate a DATA_WIDTH-bit value by s positions in the chosen direction.
   function automatic logic [DATA_WIDTH-1:0] rotPlain(
      input logic [DATA_WIDTH-1:0] d,
      input logic [AMT_WIDTH-1:0]  s,
      input logic                  right
   );
      logic [AMT_WIDTH+1:0] inv;
      inv = (AMT_WIDTH+2)'(DATA_WIDTH) - {2'b00, s};
      if (right) rotPlain = (d >> s) | (d << inv);
      else       rotPlain = (d << s) | (d >> inv);
   endfunction

   // Rotate the {carry, data} value (DATA_WIDTH+1 bits) as a single unit.
   function automatic logic [DATA_WIDTH:0] rotCarry(
      input logic [DATA_WIDTH:0]  d,
      input logic [AMT_WIDTH-1:0] s,
      input logic                 right
   );
      logic [AMT_WIDTH+1:0] inv;
      inv = (AMT_WIDTH+2)'(DATA_WIDTH + 1) - {2'b00, s};
      if (right) rotCarry = (d >> s) | (d << inv);
      else       rotCarry = (d << s) | (d >> inv);
   endfunction

   // Step size, the rotated working value and the carry it would produce.
   always_comb begin
      w_step     = (r_remaining > AMT_WIDTH'(STEP)) ? AMT_WIDTH'(STEP) : r_remaining;
      w_remNext  = r_remaining - w_step;
      w_workNext = r_work;
      if (r_thru) begin
         w_workNext = rotCarry(r_work, w_step, r_right);
      end else begin
         w_workNext = {r_work[DATA_WIDTH], rotPlain(r_work[DATA_WIDTH-1:0], w_step, r_right)};
      end
      if (r_thru)       w_finalCarry = w_workNext[DATA_WIDTH];
      else if (r_right) w_finalCarry = w_workNext[DATA_WIDTH-1];
      else              w_finalCarry = w_workNext[0];
   end

   // State register; a stalled cycle keeps the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   // Next-state decode: IDLE accepts a start, RUN finishes when nothing remains.
   always_comb begin
      w_nextState = r_state;
      if (enable) begin
         unique case (r_state)
            IDLE: if (start) w_nextState = (amount == '0) ? DONE : RUN;
            RUN:  if (w_remNext == '0) w_nextState = DONE;
            DONE: w_nextState = IDLE;
            default: w_nextState = IDLE;
         endcase
      end
   end

   // Working registers and the reported flags, written only when entering DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work      <= '0;
         r_remaining <= '0;
         r_right     <= 1'b0;
         r_thru      <= 1'b0;
         r_result    <= '0;
         r_carryOut  <= 1'b0;
         r_zero      <= 1'b0;
      end else if (enable) begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_work      <= {carry_in, a_in};
                  r_remaining <= amount;
                  r_right     <= op_right;
                  r_thru      <= op_thru_carry;
                  if (amount == '0) begin
                     r_result   <= a_in;
                     r_carryOut <= carry_in;
                     r_zero     <= (a_in == '0);
                  end
               end
            end
            RUN: begin
               r_work      <= w_workNext;
               r_remaining <= w_remNext;
               if (w_remNext == '0) begin
                  r_result   <= w_workNext[DATA_WIDTH-1:0];
                  r_carryOut <= w_finalCarry;
                  r_zero     <= (w_workNext[DATA_WIDTH-1:0] == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);
   assign result    = r_result;
   assign carry_out = r_carryOut;
   assign zero_out  = r_zero;

endmodule

// File: tb/tb_rotate_unit.sv
// tb_rotate_unit: directed vectors with hand-computed results for rotate_unit.
module tb_rotate_unit;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        start;
   logic        op_right;
   logic        op_thru_carry;
   logic [31:0] a_in;
   logic [4:0]  amount;
   logic        carry_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        carry_out;
   logic        zero_out;

   int          assertCount;
   int          failCount;
   logic [31:0] lastExp;
   int          lat;
   int          doneSeen;

   rotate_unit #(.DATA_WIDTH(32), .AMT_WIDTH(5), .STEP(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .start         (start),
      .op_right      (op_right),
      .op_thru_carry (op_thru_carry),
      .a_in          (a_in),
      .amount        (amount),
      .carry_in      (carry_in),
      .busy          (busy),
      .done          (done),
      .result        (result),
      .carry_out     (carry_out),
      .zero_out      (zero_out)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and log mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Issue one operation, optionally stalling or poking start mid-run, then check it.
   task automatic applyStimulus(
      input string       tag,
      input logic        right,
      input logic        thru,
      input logic [31:0] a,
      input logic [4:0]  amt,
      input logic        cin,
      input int          stallAt,
      input int          stallLen,
      input int          pokeAt,
      input logic [31:0] expRes,
      input logic        expCarry,
      input logic        expZero,
      input int          expLat
   );
      int n;
      op_right      = right;
      op_thru_carry = thru;
      a_in          = a;
      amount        = amt;
      carry_in      = cin;
      start         = 1'b1;
      n             = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
      n     = 1;
      if (!done) begin
         checkOutput({tag, "_hold"}, result, lastExp);
         checkOutput({tag, "_busy"}, busy, 1);
      end
      while (!done && n < 100) begin
         if (stallLen > 0 && n == stallAt) enable = 1'b0;
         if (stallLen > 0 && n == stallAt + stallLen) enable = 1'b1;
         if (pokeAt > 0 && n == pokeAt) begin
            start    = 1'b1;
            a_in     = 32'hFFFF_FFFF;
            amount   = 5'd3;
            op_right = ~right;
            carry_in = ~cin;
         end
         if (pokeAt > 0 && n == pokeAt + 1) start = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      enable = 1'b1;
      start  = 1'b0;
      checkOutput({tag, "_done"}, done, 1);
      checkOutput({tag, "_lat"}, n, expLat);
      checkOutput({tag, "_result"}, result, expRes);
      checkOutput({tag, "_carry"}, carry_out, expCarry);
      checkOutput({tag, "_zero"}, zero_out, expZero);
      @(posedge clk);
      #1;
      checkOutput({tag, "_doneDrop"}, done, 0);
      checkOutput({tag, "_idle"}, busy, 0);
      checkOutput({tag, "_keep"}, result, expRes);
      lastExp = expRes;
   endtask

   // Main sequence: reset, directed rotations, stall, ignored start, mid-run reset.
   initial begin
      assertCount   = 0;
      failCount     = 0;
      lastExp       = 32'h0;
      rst_n         = 1'b0;
      enable        = 1'b1;
      start         = 1'b0;
      op_right      = 1'b0;
      op_thru_carry = 1'b0;
      a_in          = 32'h0;
      amount        = 5'd0;
      carry_in      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_result", result, 0);
      checkOutput("rst_carry", carry_out, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus("rotl1",     0, 0, 32'h8000_0001, 5'd1,  0, 0, 0, 0, 32'h0000_0003, 1, 0, 2);
      applyStimulus("rotr4",     1, 0, 32'h0000_0001, 5'd4,  0, 0, 0, 0, 32'h1000_0000, 0, 0, 2);
      applyStimulus("zeroL",     0, 0, 32'h1234_5678, 5'd0,  1, 0, 0, 0, 32'h1234_5678, 1, 0, 1);
      applyStimulus("zeroR",     1, 0, 32'h1234_5678, 5'd0,  1, 0, 0, 0, 32'h1234_5678, 1, 0, 1);
      applyStimulus("rclThru",   0, 1, 32'h8000_0000, 5'd1,  0, 0, 0, 0, 32'h0000_0000, 1, 1, 2);
      applyStimulus("rcrThru",   1, 1, 32'h0000_0001, 5'd1,  0, 0, 0, 0, 32'h0000_0000, 1, 1, 2);
      applyStimulus("rcl4",      0, 1, 32'hF000_0000, 5'd4,  1, 0, 0, 0, 32'h0000_000F, 1, 0, 2);
      applyStimulus("rcr5",      1, 1, 32'h0000_0021, 5'd5,  0, 0, 0, 0, 32'h1000_0001, 0, 0, 3);
      applyStimulus("rotl31",    0, 0, 32'h0000_0001, 5'd31, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 9);
      applyStimulus("rotl31stl", 0, 0, 32'h0000_0001, 5'd31, 0, 3, 3, 0, 32'h8000_0000, 0, 0, 12);
      applyStimulus("ignStart",  1, 0, 32'h0001_80FF, 5'd16, 0, 0, 0, 2, 32'h80FF_0001, 1, 0, 5);

      op_right      = 1'b0;
      op_thru_carry = 1'b0;
      a_in          = 32'hA5A5_A5A5;
      amount        = 5'd16;
      carry_in      = 1'b1;
      start         = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("preRst_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midRst_busy", busy, 0);
      checkOutput("midRst_done", done, 0);
      checkOutput("midRst_result", result, 0);
      checkOutput("midRst_carry", carry_out, 0);
      checkOutput("midRst_zero", zero_out, 0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done) doneSeen++;
      end
      checkOutput("postRst_noDone", doneSeen, 0);
      checkOutput("postRst_idle", busy, 0);
      checkOutput("postRst_result", result, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/rotate_unit.md
Name: rotate_unit

Overview:
- Iterative multi-cycle rotate execution unit for the flare32 ALU path.
- It is the responder that the simulation rotate tester drives: the tester issues start plus operands, and this unit computes and reports completion.
- Supports left and right rotation, either plain (DATA_WIDTH-bit) or through carry (DATA_WIDTH+1-bit).
- Rotates up to STEP bits per cycle under a start/busy/done handshake.

Parameters:
- DATA_WIDTH, 32: operand and result width.
- AMT_WIDTH, 5: rotate amount width, equal to log2(DATA_WIDTH).
- STEP, 4: maximum bit positions rotated per RUN cycle. Legal range is 1..DATA_WIDTH-1.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: global stall. When low, all state and outputs hold.
- start, input, 1: request. Accepted only when enable=1 and busy=0.
- op_right, input, 1: 1 = rotate right, 0 = rotate left.
- op_thru_carry, input, 1: 1 = rotate through carry, treating {carry, data} as a DATA_WIDTH+1-bit value.
- a_in, input, DATA_WIDTH: operand.
- amount, input, AMT_WIDTH: rotate count, 0..DATA_WIDTH-1.
- carry_in, input, 1: incoming carry flag.
- busy, output, 1: high in RUN and DONE.
- done, output, 1: one-cycle completion pulse.
- result, output, DATA_WIDTH: rotated value.
- carry_out, output, 1: resulting carry flag.
- zero_out, output, 1: result == 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - busy, done, result, carry_out and zero_out all go to 0.
  - Any in-flight operation is aborted. Nothing is reported afterwards.
- States are IDLE, RUN and DONE. When enable=0, no transition occurs and no register changes.
- IDLE:
  - Outputs result, carry_out and zero_out hold their last values.
  - On an edge with start=1 and enable=1, latch a_in, carry_in, op_right and op_thru_carry into working registers.
  - Set remaining = amount.
  - Next state is DONE if amount==0, otherwise RUN.
- RUN, each enabled edge:
  - Rotate the working value by s = min(remaining, STEP) in the latched direction.
  - Set remaining -= s.
  - Go to DONE when remaining becomes 0.
  - Number of RUN cycles N = ceil(amount/STEP).
- Plain mode:
  - The working register is DATA_WIDTH bits.
  - Left rotate: carry_out = result[0]. Right rotate: carry_out = result[DATA_WIDTH-1].
  - If amount==0: carry_out = latched carry_in.
- Through-carry mode:
  - The working register is {c, data}, DATA_WIDTH+1 bits, rotated as a unit.
  - Final c becomes carry_out and data becomes result.
  - amount is never taken modulo here (max 31 < 33).
- DONE:
  - done=1 for exactly one enabled cycle.
  - result, carry_out and zero_out are valid from this cycle onward.
  - Next state is IDLE.
  - If enable drops while in DONE, done stays high until the cycle in which enable returns, then clears.
- Latency: done is high in cycle start_cycle + N + 1 when enable is held high. For amount==0, done is high in the cycle after start.
- start while busy=1 (RUN or DONE) is ignored. Nothing is queued, and in-flight operands are not disturbed. Input changes during RUN have no effect.
- Outputs result, carry_out and zero_out update only on the edge entering DONE, and hold until the next operation's DONE. Intermediate values are never visible on result.
- enable low mid-RUN extends latency by exactly the number of stalled cycles.

Test Plan:
1. Rotl, plain: a_in=0x80000001, amount=1, carry_in=0 -> result=0x00000003, carry_out=1, zero_out=0. done exactly 2 cycles after start (N=1).
2. Rotr, plain: a_in=0x00000001, amount=4 -> result=0x10000000, carry_out=0, N=1. done 2 cycles after start.
3. amount=0, a_in=0x12345678, carry_in=1, either direction -> result=0x12345678, carry_out=1. done the cycle after start.
4. Rotl through carry: a_in=0x80000000, carry_in=0, amount=1 -> result=0x00000000, carry_out=1, zero_out=1.
5. Rotl, plain: a_in=0x00000001, amount=31 -> result=0x80000000, carry_out=0, 8 RUN cycles, done 9 cycles after start.
   - Repeat with enable low for 3 cycles mid-RUN -> done at 12 cycles, same result.
6. Robustness and reset:
   - Start with amount=16, then pulse start again with different operands at cycle 2 -> ignored; first result reported.
   - Then start again and assert rst_n=0 during RUN -> busy, done, result, carry_out and zero_out read 0 immediately.
   - After release, no done pulse occurs until a new start.
